// File: rtl/reg_scoreboard_pkg.sv
// Shared definitions for the register scoreboard.
// Provides register index widths, the PC index (never tracked), default
// counter widths and a helper that decodes an enabled register index into
// a one-hot vector over the tracked registers.
package reg_scoreboard_pkg;

  localparam int         REG_IDX_W = 4;
  localparam int         NUM_REGS  = 15;
  localparam logic [3:0] PC_IDX    = 4'd15;
  localparam int         CNT_W     = 2;
  localparam int         STAT_W    = 16;

  // One-hot select over R0..R14; index 15 (PC) decodes to all zeros.
  function automatic logic [NUM_REGS-1:0] reg_onehot(
    input logic                 en,
    input logic [REG_IDX_W-1:0] idx
  );
    logic [NUM_REGS-1:0] vec;
    vec = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      vec[r] = en && (idx == REG_IDX_W'(r));
    end
    return vec;
  endfunction

endpackage

// File: rtl/reg_scoreboard_counter.sv
// sb_counter: one per-register pending-write counter.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   inc               accepted issue targets this register
//   dec_wb, dec_kill  write-back / kill targets this register
//   cnt_q             current pending count
//   cnt_d             next pending count (for registered busy in the top)
//   underflow         a decrement this cycle would have gone below zero
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_wb,
  input  logic             dec_kill,
  output logic [CNT_W-1:0] cnt_q,
  output logic [CNT_W-1:0] cnt_d,
  output logic             underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W:0] up_sum;
  logic [CNT_W:0] dn_sum;
  logic [CNT_W:0] diff;

  // Net update of all coincident events in one step, clamped to [0, CNT_MAX].
  always_comb begin
    up_sum    = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
    dn_sum    = {{CNT_W{1'b0}}, dec_wb} + {{CNT_W{1'b0}}, dec_kill};
    diff      = up_sum - dn_sum;
    underflow = 1'b0;
    if (up_sum < dn_sum) begin
      cnt_d     = {CNT_W{1'b0}};
      underflow = 1'b1;
    end else if (diff > {1'b0, CNT_MAX}) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = diff[CNT_W-1:0];
    end
  end

  // Counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: tracks pending register writes between ID and WB and
// stalls decode on read-after-write hazards or pending-counter overflow.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   issue_*                   instruction presented by ID this cycle
//   wb_en, wb_dest            write-back retiring a pending write
//   kill_en, kill_dest        flushed instruction cancelling its pending write
//   stall                     combinational: hold IF/ID, instruction not accepted
//   busy                      registered: some register has a pending write
//   err                       sticky: decrement of a zero counter seen
//   stall_cycles              saturating count of stalled cycles
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int CNT_W_P  = CNT_W,
  parameter int STAT_W_P = STAT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic                 issue_wb_en,
  input  logic [3:0]           issue_dest,
  input  logic [3:0]           issue_src_1,
  input  logic [3:0]           issue_src_2,
  input  logic                 issue_two_src,
  input  logic                 wb_en,
  input  logic [3:0]           wb_dest,
  input  logic                 kill_en,
  input  logic [3:0]           kill_dest,
  output logic                 stall,
  output logic                 busy,
  output logic                 err,
  output logic [STAT_W_P-1:0]  stall_cycles
);

  localparam logic [CNT_W_P-1:0] CNT_ONE = CNT_W_P'(1'b1);
  localparam logic [CNT_W_P-1:0] CNT_MX  = {CNT_W_P{1'b1}};

  logic [CNT_W_P-1:0]  cnt_q [NUM_REGS];
  logic [CNT_W_P-1:0]  cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] kill_hit;
  logic [NUM_REGS-1:0] dest_hit;
  logic [NUM_REGS-1:0] inc;
  logic [NUM_REGS-1:0] underflow;
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] full;
  logic [15:0]         pend_ix;
  logic [15:0]         full_ix;
  logic                accept;

  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic [STAT_W_P-1:0] stall_cycles_q, stall_cycles_d;

  assign wb_hit   = reg_onehot(wb_en, wb_dest);
  assign kill_hit = reg_onehot(kill_en, kill_dest);
  assign dest_hit = reg_onehot(issue_wb_en, issue_dest);
  assign inc      = accept ? dest_hit : {NUM_REGS{1'b0}};

  genvar r;
  generate
    for (r = 0; r < NUM_REGS; r++) begin : g_reg
      sb_counter #(.CNT_W(CNT_W_P)) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (inc[r]),
        .dec_wb    (wb_hit[r]),
        .dec_kill  (kill_hit[r]),
        .cnt_q     (cnt_q[r]),
        .cnt_d     (cnt_d[r]),
        .underflow (underflow[r])
      );
      // A same-cycle write-back lands on the negedge write port, so it
      // already satisfies one pending write for readers in this cycle.
      assign pend[r] = (cnt_q[r] != {CNT_W_P{1'b0}}) && !((cnt_q[r] == CNT_ONE) && wb_hit[r]);
      assign full[r] = (cnt_q[r] == CNT_MX) && !wb_hit[r];
    end
  endgenerate

  // Index 15 (PC) is never pending and never full.
  assign pend_ix = {1'b0, pend};
  assign full_ix = {1'b0, full};

  // Hazard detection and acceptance.
  always_comb begin
    stall  = issue_valid &&
             (pend_ix[issue_src_1] ||
              (issue_two_src && pend_ix[issue_src_2]) ||
              (issue_wb_en && full_ix[issue_dest]));
    accept = issue_valid && !stall;
  end

  // Next state for sticky error, busy and stall statistics.
  always_comb begin
    err_d  = err_q | (|underflow);
    busy_d = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_d = busy_d | (|cnt_d[i]);
    end
    if (stall && (stall_cycles_q != {STAT_W_P{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + {{(STAT_W_P-1){1'b0}}, 1'b1};
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
      stall_cycles_q <= {STAT_W_P{1'b0}};
    end else begin
      busy_q         <= busy_d;
      err_q          <= err_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign busy         = busy_q;
  assign err          = err_q;
  assign stall_cycles = stall_cycles_q;

endmodule
